// File: rtl/bus_mux_sync_tx_if.sv
// Handshake/bus bundle between the source-domain sender and its environment.
// master: the sender (drives Ready, Unsync_Bus, Enable; receives Data_In, Data_Valid, Ack).
// slave:  the upstream producer plus destination side (drives Data_In, Data_Valid, Ack).
interface bus_mux_sync_tx_if #(
    parameter int UNSYNC_BUS_WIDTH = 8
);
    logic [UNSYNC_BUS_WIDTH-1:0] Data_In;
    logic                        Data_Valid;
    logic                        Ready;
    logic                        Ack;
    logic [UNSYNC_BUS_WIDTH-1:0] Unsync_Bus;
    logic                        Enable;

    modport master (
        input  Data_In,
        input  Data_Valid,
        input  Ack,
        output Ready,
        output Unsync_Bus,
        output Enable
    );

    modport slave (
        output Data_In,
        output Data_Valid,
        output Ack,
        input  Ready,
        input  Unsync_Bus,
        input  Enable
    );
endinterface

// File: rtl/bus_mux_sync_tx.sv
// Source-domain sender for a bus MUX synchronizer: captures a word, freezes it on
// Unsync_Bus and drives a level Enable to the destination (IDLE->SETUP->REQ->RELEASE).
// Latency: Enable rises after the 2nd edge from accept; Ready only while IDLE, requests
// while busy are dropped (upstream must hold or retry).
//
// Ports: clk, rst (async, active-high); bus (master modport): Data_In, Data_Valid, Ack in;
//        Ready, Unsync_Bus, Enable out (all registered / decoded from registers).
// Build option BUS_SYNC_TX_ACK_EN: defined -> closed-loop four-phase handshake on a
// NUM_STAGES-flop synchronized Ack (no timeout); undefined -> open-loop, REQ and
// RELEASE each last HOLD_CYCLES clocks and Ack is ignored.
// HOLD_CYCLES must be at least NUM_STAGES+2 so the destination has time to sample.
module bus_mux_sync_tx #(
    parameter int NUM_STAGES       = 2,
    parameter int UNSYNC_BUS_WIDTH = 8,
    parameter int HOLD_CYCLES      = 4
) (
    input  logic             clk,
    input  logic             rst,
    bus_mux_sync_tx_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [UNSYNC_BUS_WIDTH-1:0] bus_q, bus_d;
    logic                        en_q, en_d;

    // Exit qualifiers for REQ and RELEASE, produced by whichever mode is built.
    logic                        req_done;
    logic                        rel_done;

`ifdef BUS_SYNC_TX_ACK_EN
    // Ack is the destination's synchronized Enable returned as a level; bring it
    // into this domain before the FSM looks at it.
    logic [NUM_STAGES-1:0]       sync_q;
    logic                        ack_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], bus.Ack};
        end
    end

    assign ack_s    = sync_q[NUM_STAGES-1];
    assign req_done = ack_s;
    assign rel_done = !ack_s;
`else
    localparam int            CNT_W     = $clog2(HOLD_CYCLES + 1);
    // Loaded with HOLD_CYCLES-1 so that the state is left on the edge where the
    // counter reads zero, giving exactly HOLD_CYCLES cycles in the state.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        cnt_load;
    logic                        unused_ack;

    assign unused_ack = bus.Ack;
    assign cnt_load   = (state_q == SETUP) || ((state_q == REQ) && req_done);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_load) begin
            cnt_d = HOLD_LOAD;
        end else if (cnt_q != '0) begin
            // Saturating count-down: parks at zero instead of wrapping.
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign req_done = (cnt_q == '0);
    assign rel_done = (cnt_q == '0);
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        en_d    = en_q;
        unique case (state_q)
            IDLE: begin
                if (bus.Data_Valid) begin
                    bus_d   = bus.Data_In;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // Bus has had a full cycle to settle; now raise the request.
                en_d    = 1'b1;
                state_d = REQ;
            end
            REQ: begin
                if (req_done) begin
                    en_d    = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Bus stays frozen until the destination is known to be done.
                if (rel_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bus_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
        end
    end

    assign bus.Ready      = (state_q == IDLE);
    assign bus.Unsync_Bus = bus_q;
    assign bus.Enable     = en_q;

endmodule

// File: tb/tb_bus_mux_sync_tx.sv
module tb_bus_mux_sync_tx;

    logic clk  = 1'b0;
    logic dclk = 1'b0;
    logic rst  = 1'b1;

    always #5 clk  = ~clk;
    always #6 dclk = ~dclk;

    bus_mux_sync_tx_if #(.UNSYNC_BUS_WIDTH(8)) bif ();

    bus_mux_sync_tx #(
        .NUM_STAGES      (2),
        .UNSYNC_BUS_WIDTH(8),
        .HOLD_CYCLES     (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Destination-side Data_Sync model: two-flop synchronizer on its own clock,
    // one Enable_Pulse per rising synchronized Enable, sampling the bus then.
    logic [1:0] d_sync = 2'b00;
    logic       d_prev = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_q[$];

    always @(posedge dclk) begin
        d_sync <= {d_sync[0], bif.Enable};
        d_prev <= d_sync[1];
        if (d_sync[1] && !d_prev) begin
            rx_cnt <= rx_cnt + 1;
            rx_q.push_back(bif.Unsync_Bus);
        end
    end

    // Accept a word: returns at the negedge after the accept edge E0 (cycle 1).
    task automatic send(input logic [7:0] w);
        @(negedge clk);
        bif.Data_In    = w;
        bif.Data_Valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.Data_Valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++; if (bif.Ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", bif.Ready); end
        vectors++; if (bif.Enable !== 1'b0) begin miscompares++; $display("FAIL rst_enable got %b want 0", bif.Enable); end
        vectors++; if (bif.Unsync_Bus !== 8'h00) begin miscompares++; $display("FAIL rst_bus got %h want 00", bif.Unsync_Bus); end
        // Data_Valid while in reset must not start anything.
        bif.Data_In = 8'h77; bif.Data_Valid = 1'b1;
        @(negedge clk);
        vectors++; if (bif.Ready !== 1'b1 || bif.Unsync_Bus !== 8'h00) begin miscompares++; $display("FAIL rst_dv_ignored ready %b bus %h want 1 00", bif.Ready, bif.Unsync_Bus); end
        bif.Data_Valid = 1'b0;
        rst = 1'b0;
        // Reset mid-REQ with A5 on the bus.
        send(8'hA5);
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bif.Enable !== 1'b1 || bif.Unsync_Bus !== 8'hA5) begin miscompares++; $display("FAIL rst_pre_req en %b bus %h want 1 a5", bif.Enable, bif.Unsync_Bus); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (bif.Enable !== 1'b0) begin miscompares++; $display("FAIL rst_mid_enable got %b want 0", bif.Enable); end
        vectors++; if (bif.Unsync_Bus !== 8'h00) begin miscompares++; $display("FAIL rst_mid_bus got %h want 00", bif.Unsync_Bus); end
        vectors++; if (bif.Ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready got %b want 1", bif.Ready); end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        vectors++; if (bif.Ready !== 1'b1 || bif.Enable !== 1'b0) begin miscompares++; $display("FAIL rst_idle ready %b en %b want 1 0", bif.Ready, bif.Enable); end
    endtask

`ifndef BUS_SYNC_TX_ACK_EN
    task automatic test_open_loop;
        int   rx0;
        logic exp_en, exp_rdy;
        rx0 = rx_cnt;
        send(8'h3C);
        vectors++; if (bif.Unsync_Bus !== 8'h3C) begin miscompares++; $display("FAIL open_bus got %h want 3c", bif.Unsync_Bus); end
        vectors++; if (bif.Ready !== 1'b0 || bif.Enable !== 1'b0) begin miscompares++; $display("FAIL open_setup ready %b en %b want 0 0", bif.Ready, bif.Enable); end
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            // Ack wiggles must have no effect in open-loop mode.
            if (k == 3) bif.Ack = 1'b1;
            if (k == 7) bif.Ack = 1'b0;
            exp_en  = (k >= 2 && k <= 5);
            exp_rdy = (k >= 10);
            vectors++; if (bif.Enable !== exp_en) begin miscompares++; $display("FAIL open_enable cyc%0d got %b want %b", k, bif.Enable, exp_en); end
            vectors++; if (bif.Ready !== exp_rdy) begin miscompares++; $display("FAIL open_ready cyc%0d got %b want %b", k, bif.Ready, exp_rdy); end
        end
        vectors++; if (rx_cnt - rx0 !== 1) begin miscompares++; $display("FAIL open_pulses got %0d want 1", rx_cnt - rx0); end
        vectors++; if (rx_q.size() == 0 || rx_q[rx_q.size()-1] !== 8'h3C) begin miscompares++; $display("FAIL open_sync_bus got %h want 3c", (rx_q.size() == 0) ? 8'hxx : rx_q[rx_q.size()-1]); end
    endtask

    task automatic test_busy;
        int   rx0;
        logic exp_en, exp_rdy;
        rx0 = rx_cnt;
        send(8'h3C);
        for (int k = 2; k <= 13; k++) begin
            @(negedge clk);
            // One-cycle requests during REQ (cycle 3) and RELEASE (cycle 7).
            if (k == 3 || k == 7) begin bif.Data_In = 8'h55; bif.Data_Valid = 1'b1; end
            if (k == 4 || k == 8) bif.Data_Valid = 1'b0;
            exp_en  = (k >= 2 && k <= 5);
            exp_rdy = (k >= 10);
            vectors++; if (bif.Unsync_Bus !== 8'h3C) begin miscompares++; $display("FAIL busy_bus cyc%0d got %h want 3c", k, bif.Unsync_Bus); end
            vectors++; if (bif.Enable !== exp_en || bif.Ready !== exp_rdy) begin miscompares++; $display("FAIL busy_ctl cyc%0d en %b rdy %b want %b %b", k, bif.Enable, bif.Ready, exp_en, exp_rdy); end
        end
        vectors++; if (rx_cnt - rx0 !== 1) begin miscompares++; $display("FAIL busy_pulses got %0d want 1", rx_cnt - rx0); end
    endtask

    task automatic test_back_to_back;
        int   rx0;
        logic exp_en, exp_rdy;
        rx0 = rx_cnt;
        send(8'h01);
        // send() dropped Data_Valid; re-assert it at once with the next word so
        // Data_Valid is held high from the accept edge onward.
        bif.Data_In = 8'h02; bif.Data_Valid = 1'b1;
        // Cycle k is the cycle after edge E(k-1); second accept is edge E10, so its
        // SETUP cycle is cycle 11 of the first transfer.
        for (int k = 2; k <= 22; k++) begin
            @(negedge clk);
            if (k == 11) bif.Data_Valid = 1'b0;
            exp_en  = (k >= 2 && k <= 5) || (k >= 12 && k <= 15);
            exp_rdy = (k == 10) || (k >= 20);
            vectors++; if (bif.Enable !== exp_en || bif.Ready !== exp_rdy) begin miscompares++; $display("FAIL b2b_ctl cyc%0d en %b rdy %b want %b %b", k, bif.Enable, bif.Ready, exp_en, exp_rdy); end
            if (k == 10) begin
                vectors++; if (bif.Unsync_Bus !== 8'h01) begin miscompares++; $display("FAIL b2b_not_early got %h want 01", bif.Unsync_Bus); end
            end
            if (k == 11) begin
                vectors++; if (bif.Unsync_Bus !== 8'h02) begin miscompares++; $display("FAIL b2b_second got %h want 02", bif.Unsync_Bus); end
            end
        end
        vectors++; if (rx_cnt - rx0 !== 2) begin miscompares++; $display("FAIL b2b_pulses got %0d want 2", rx_cnt - rx0); end
        vectors++; if (rx_q.size() < 2 || rx_q[rx_q.size()-2] !== 8'h01 || rx_q[rx_q.size()-1] !== 8'h02) begin miscompares++; $display("FAIL b2b_order got %h %h want 01 02", (rx_q.size() < 2) ? 8'hxx : rx_q[rx_q.size()-2], (rx_q.size() < 2) ? 8'hxx : rx_q[rx_q.size()-1]); end
    endtask
`else
    task automatic test_ack_handshake;
        logic exp;
        int   n;
        send(8'h96);
        n = 0;
        while (bif.Enable !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        vectors++; if (bif.Enable !== 1'b1) begin miscompares++; $display("FAIL ack_enable_rise got %b want 1 (timeout)", bif.Enable); end
        repeat (5) @(negedge clk);
        bif.Ack = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            exp = (e < 3);
            vectors++; if (bif.Enable !== exp) begin miscompares++; $display("FAIL ack_fall edge%0d got %b want %b", e, bif.Enable, exp); end
        end
        repeat (4) @(negedge clk);
        vectors++; if (bif.Ready !== 1'b0 || bif.Unsync_Bus !== 8'h96) begin miscompares++; $display("FAIL ack_release rdy %b bus %h want 0 96", bif.Ready, bif.Unsync_Bus); end
        bif.Ack = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            exp = (e == 3);
            vectors++; if (bif.Ready !== exp) begin miscompares++; $display("FAIL ack_ready edge%0d got %b want %b", e, bif.Ready, exp); end
        end
        vectors++; if (rx_q.size() == 0 || rx_q[rx_q.size()-1] !== 8'h96) begin miscompares++; $display("FAIL ack_sync_bus got %h want 96", (rx_q.size() == 0) ? 8'hxx : rx_q[rx_q.size()-1]); end
    endtask

    task automatic test_ack_stuck;
        send(8'h5A);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            repeat (10) @(negedge clk);
            vectors++; if (bif.Enable !== 1'b1 || bif.Ready !== 1'b0) begin miscompares++; $display("FAIL stuck_hold chk%0d en %b rdy %b want 1 0", k, bif.Enable, bif.Ready); end
        end
        #2 rst = 1'b1;
        #1;
        vectors++; if (bif.Enable !== 1'b0 || bif.Ready !== 1'b1 || bif.Unsync_Bus !== 8'h00) begin miscompares++; $display("FAIL stuck_rst en %b rdy %b bus %h want 0 1 00", bif.Enable, bif.Ready, bif.Unsync_Bus); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (bif.Ready !== 1'b1) begin miscompares++; $display("FAIL stuck_idle got %b want 1", bif.Ready); end
    endtask
`endif

    initial begin
        bif.Data_In    = 8'h00;
        bif.Data_Valid = 1'b0;
        bif.Ack        = 1'b0;
        test_reset();
`ifndef BUS_SYNC_TX_ACK_EN
        test_open_loop();
        test_busy();
        test_back_to_back();
`else
        test_ack_handshake();
        test_ack_stuck();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
